pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Run controller for the single-cycle MIPS core's next-PC datapath.
- Owns the architectural PC register and sequences each instruction: fetch handshake with instruction memory, then one execute/commit cycle in which the externally computed next-PC and halt are applied.
- Provides board-level run control: start, resume after syscall halt, single-step, fetch timeout error, and cycle/instruction statistics counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_BITS, 32, width of the cycle and instruction counters.
- ACK_TIMEOUT, 16, maximum number of FETCH cycles to wait for im_ack; 0 disables the timeout.
- TO_BITS, 8, width of the timeout counter; must satisfy ACK_TIMEOUT < 2^TO_BITS.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  start/resume/step request; level input, rising edge detected internally.
- step_mode  in  1  1 = pause after every committed instruction.
- next_pc  in  32  next-PC from the next-PC datapath; valid in EXEC.
- halt  in  1  syscall-halt flag from the next-PC datapath; valid in EXEC.
- im_ack  in  1  instruction memory data valid.
- pc  out  32  current PC, registered.
- im_req  out  1  fetch request; equals (state==FETCH).
- ir_load  out  1  latch instruction register; equals (state==FETCH && im_ack).
- commit  out  1  instruction retires this cycle; equals (state==EXEC).
- running  out  1  state is FETCH or EXEC.
- halted  out  1  state is HALT.
- paused  out  1  state is PAUSE.
- bus_err  out  1  state is ERR.
- cycle_count  out  CNT_BITS  number of cycles spent in FETCH or EXEC.
- instr_count  out  CNT_BITS  number of committed instructions.

Behaviour:
- States: IDLE, FETCH, EXEC, HALT, PAUSE, ERR. All outputs are decoded from registered state or are registers.
- Reset: rst sampled high sets state=IDLE, pc=RESET_PC, counters=0, timeout counter=0, go_q=0.
  - All flag outputs are 0 in IDLE.
  - rst overrides every other input in the same cycle.
  - rst in any state, including mid-FETCH, behaves identically; im_req drops the cycle after rst is sampled.
- go edge detection: go_q<=go every cycle; go_rise = go & ~go_q. go_rise is ignored in FETCH, EXEC and ERR.
- IDLE: go_rise -> FETCH.
- FETCH:
  - Timeout counter is cleared on entry and increments each FETCH cycle; k denotes the FETCH cycle index, starting at 0.
  - im_ack=1 -> EXEC; the ack is accepted at any k <= ACK_TIMEOUT-1.
  - No ack at k = ACK_TIMEOUT-1 (with ACK_TIMEOUT != 0) -> ERR.
  - Minimum fetch latency is 1 cycle (ack at k=0).
- EXEC: exactly 1 cycle.
  - pc <= next_pc unconditionally, including on halt.
  - Then: halt=1 -> HALT; else step_mode=1 -> PAUSE; else -> FETCH.
  - halt and step_mode both 1 -> HALT.
- HALT, PAUSE: im_req=0, pc held; go_rise -> FETCH.
- ERR: sticky until rst; pc held; im_req=0.
- im_ack outside FETCH is ignored.
- Throughput: 2 cycles per instruction with zero-wait memory.
- Counters:
  - instr_count +1 on each commit; cycle_count +1 each cycle in FETCH or EXEC.
  - Both saturate at all-ones and never wrap.
  - Neither counts in IDLE, HALT, PAUSE or ERR.
- PC arithmetic: 32-bit, no alignment check; a next_pc wrap from 0xFFFF_FFFC to 0 is accepted as supplied.

Test Plan:
- Start and sequence: reset, then go pulse; im_ack=1 at k=0; next_pc=pc+4 each EXEC -> im_req first seen the cycle after go_rise; pc sequence 0x0, 0x4, 0x8; commit every 2nd cycle; after 3 commits instr_count=3, cycle_count=6.
- Syscall halt and resume: halt=1 with next_pc=0x1C in EXEC -> pc=0x1C, halted=1, im_req=0 held 10 cycles with counters frozen; go pulse -> im_req=1 the next cycle, halted=0.
- Single-step: step_mode=1 -> exactly one commit per go pulse, with paused=1 between steps; go held high 5 cycles produces only one step; halt=1 and step_mode=1 together -> halted=1, paused=0.
- Timeout: ACK_TIMEOUT=16, no ack -> bus_err=1 the cycle after k=15; im_ack at k=15 -> EXEC, no error; bus_err stays set despite go and im_ack until rst.
- Saturation: CNT_BITS=4, 20 instructions executed -> instr_count stays 4'hF and cycle_count stays 4'hF.
- Reset mid-operation: rst during FETCH at k=3 with pc=0x40 -> next cycle pc=RESET_PC, im_req=0, state IDLE, both counters 0; a late im_ack produces no ir_load.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch/next-PC bus between the run controller and the core datapath / instruction memory.
interface pc_sequencer_if;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        halt;
  logic        im_req;
  logic        im_ack;
  logic        ir_load;
  logic        commit;

  modport master (
    output pc, im_req, ir_load, commit,
    input  next_pc, halt, im_ack
  );

  modport slave (
    input  pc, im_req, ir_load, commit,
    output next_pc, halt, im_ack
  );
endinterface

// File: rtl/pc_sequencer.sv
// Run controller for the single-cycle MIPS next-PC path: owns the PC, sequences
// fetch/execute, and provides start/resume/step control, fetch timeout and statistics.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned CNT_BITS    = 32,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned TO_BITS     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic                step_mode,
  pc_sequencer_if.master      bus,
  output logic                running,
  output logic                halted,
  output logic                paused,
  output logic                bus_err,
  output logic [CNT_BITS-1:0] cycle_count,
  output logic [CNT_BITS-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_PAUSE,
    S_ERR
  } state_t;

  // Last FETCH cycle index at which an ack is still accepted.
  localparam logic [TO_BITS-1:0] TO_LAST =
    (ACK_TIMEOUT == 0) ? '0 : TO_BITS'(ACK_TIMEOUT - 1);

  state_t             state;
  state_t             state_next;
  logic               go_q;
  logic               go_rise;
  logic [TO_BITS-1:0] to_cnt;
  logic [31:0]        pc_q;
  logic               im_req_d;
  logic               ir_load_d;
  logic               commit_d;

  assign go_rise = go & ~go_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      go_q        <= 1'b0;
      to_cnt      <= '0;
      pc_q        <= RESET_PC;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      state  <= state_next;
      go_q   <= go;
      // Cleared outside FETCH so it always reads 0 on the first FETCH cycle.
      to_cnt <= (state == S_FETCH) ? to_cnt + 1'b1 : '0;
      if (commit_d) begin
        pc_q <= bus.next_pc;
        if (instr_count != '1) instr_count <= instr_count + 1'b1;
      end
      if (running && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (go_rise) state_next = S_FETCH;
      S_FETCH: begin
        if (bus.im_ack)
          state_next = S_EXEC;
        else if (ACK_TIMEOUT != 0 && to_cnt == TO_LAST)
          state_next = S_ERR;
      end
      S_EXEC: begin
        if (bus.halt)      state_next = S_HALT;
        else if (step_mode) state_next = S_PAUSE;
        else               state_next = S_FETCH;
      end
      S_HALT, S_PAUSE: if (go_rise) state_next = S_FETCH;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    im_req_d  = (state == S_FETCH);
    ir_load_d = (state == S_FETCH) && bus.im_ack;
    commit_d  = (state == S_EXEC);
    running   = (state == S_FETCH) || (state == S_EXEC);
    halted    = (state == S_HALT);
    paused    = (state == S_PAUSE);
    bus_err   = (state == S_ERR);
  end

  assign bus.pc      = pc_q;
  assign bus.im_req  = im_req_d;
  assign bus.ir_load = ir_load_d;
  assign bus.commit  = commit_d;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: committed PCs are queued by stimulus and checked
// by a monitor; run-control status is checked against hand-computed constants.
module tb_pc_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic       step_mode = 1'b0;
  logic       running, halted, paused, bus_err;
  logic [3:0] cycle_count, instr_count;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  logic [31:0] exp_q[$];

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .CNT_BITS    (4),
    .ACK_TIMEOUT (16),
    .TO_BITS     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .step_mode   (step_mode),
    .bus         (bus),
    .running     (running),
    .halted      (halted),
    .paused      (paused),
    .bus_err     (bus_err),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every commit must match the oldest queued PC.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.commit === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected: got pc %h expected no commit at %0t", bus.pc, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.pc !== e) begin
          errors++;
          $display("FAIL commit_pc: got %h expected %h at %0t", bus.pc, e, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; go = 1'b0; step_mode = 1'b0;
    bus.im_ack = 1'b0; bus.halt = 1'b0; bus.next_pc = '0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  // Starts in FETCH k=0; waits wait_k cycles, acks, then supplies next_pc/halt in EXEC.
  task automatic fetch_exec(input int wait_k, input logic [31:0] npc, input logic h,
                            input logic [31:0] exp_pc);
    bus.im_ack = 1'b0;
    repeat (wait_k) cyc();
    bus.im_ack = 1'b1;
    #1;
    chk("ir_load", 32'(bus.ir_load), 32'd1);
    exp_q.push_back(exp_pc);
    cyc();
    bus.im_ack = 1'b0; bus.next_pc = npc; bus.halt = h;
    cyc();
    bus.halt = 1'b0;
  endtask

  task automatic go_pulse();
    go = 1'b1;
    cyc();
    go = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_flags", {bus.im_req, bus.commit, running, halted, paused, bus_err}, 32'h0);
    chk("rst_cnt", {cycle_count, instr_count}, 32'h0);

    // Start and sequential run
    cyc();
    chk("idle_im_req", 32'(bus.im_req), 32'd0);
    go_pulse();
    chk("start_im_req", 32'(bus.im_req), 32'd1);
    fetch_exec(0, 32'h4, 1'b0, 32'h0);
    fetch_exec(0, 32'h8, 1'b0, 32'h4);
    fetch_exec(0, 32'hC, 1'b0, 32'h8);
    chk("seq_pc", bus.pc, 32'hC);
    chk("seq_instr", 32'(instr_count), 32'd3);
    chk("seq_cycle", 32'(cycle_count), 32'd6);

    // Syscall halt and resume
    fetch_exec(0, 32'h1C, 1'b1, 32'hC);
    chk("halt_pc", bus.pc, 32'h1C);
    chk("halt_flag", {halted, bus.im_req, running}, 32'b100);
    bus.im_ack = 1'b1;
    repeat (10) cyc();
    bus.im_ack = 1'b0;
    chk("halt_hold", {halted, bus.im_req, bus.ir_load}, 32'b100);
    chk("halt_cnt", {cycle_count, instr_count}, {24'h0, 4'd8, 4'd4});
    go_pulse();
    chk("resume", {bus.im_req, halted}, 32'b10);

    // Single-step
    step_mode = 1'b1;
    fetch_exec(0, 32'h20, 1'b0, 32'h1C);
    chk("step1_paused", {paused, bus.im_req}, 32'b10);
    chk("step1_pc", bus.pc, 32'h20);
    go = 1'b1;
    cyc();
    fetch_exec(0, 32'h24, 1'b0, 32'h20);
    cyc(); cyc();
    go = 1'b0;
    chk("step_held_go", {paused, bus.im_req}, 32'b10);
    chk("step_held_cnt", {cycle_count, instr_count}, {24'h0, 4'd12, 4'd6});
    cyc();
    go_pulse();
    fetch_exec(0, 32'h40, 1'b1, 32'h24);
    chk("halt_over_step", {halted, paused}, 32'b10);
    chk("halt_step_cnt", {cycle_count, instr_count}, {24'h0, 4'd14, 4'd7});
    step_mode = 1'b0;

    // Ack accepted on the last allowed cycle, then timeout
    go_pulse();
    fetch_exec(15, 32'h44, 1'b0, 32'h40);
    chk("late_ack_noerr", {bus_err, bus.im_req}, 32'b01);
    chk("late_ack_pc", bus.pc, 32'h44);
    chk("cycle_sat_a", 32'(cycle_count), 32'hF);
    repeat (15) cyc();
    chk("to_k15", {bus_err, bus.im_req}, 32'b01);
    cyc();
    chk("to_err", {bus_err, bus.im_req, running}, 32'b100);
    go = 1'b1; bus.im_ack = 1'b1;
    #1;
    chk("err_no_ir_load", 32'(bus.ir_load), 32'd0);
    cyc(); go = 1'b0; cyc(); go_pulse(); cyc();
    bus.im_ack = 1'b0;
    chk("err_sticky", {bus_err, bus.im_req}, 32'b10);
    chk("err_pc", bus.pc, 32'h44);

    // Counter saturation and PC wrap
    do_reset();
    chk("rst2_cnt", {cycle_count, instr_count, 1'b0, bus_err}, 32'h0);
    go_pulse();
    for (int i = 0; i < 20; i++)
      fetch_exec(0, 32'(4 * (i + 1)), 1'b0, 32'(4 * i));
    chk("sat_instr", 32'(instr_count), 32'hF);
    chk("sat_cycle", 32'(cycle_count), 32'hF);
    fetch_exec(0, 32'hFFFF_FFFC, 1'b0, 32'h50);
    fetch_exec(0, 32'h0, 1'b0, 32'hFFFF_FFFC);
    chk("pc_wrap", bus.pc, 32'h0);

    // Reset in the middle of a fetch
    do_reset();
    go_pulse();
    fetch_exec(0, 32'h40, 1'b0, 32'h0);
    repeat (3) cyc();
    chk("mid_pc", bus.pc, 32'h40);
    chk("mid_req", 32'(bus.im_req), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_pc", bus.pc, 32'h0);
    chk("mid_rst_flags", {bus.im_req, running, halted, paused, bus_err}, 32'h0);
    chk("mid_rst_cnt", {cycle_count, instr_count}, 32'h0);
    bus.im_ack = 1'b1;
    #1;
    chk("late_ack_ir", 32'(bus.ir_load), 32'd0);
    cyc();
    chk("late_ack_idle", {bus.im_req, bus.ir_load, running}, 32'h0);
    bus.im_ack = 1'b0;
    cyc();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
